// File: rtl/mips_bus_pkg.sv
// Shared bus layouts and encodings for the MIPS core pipeline stages.
//   exe_mem_t : registered EXE->MEM bus (154 bits)
//   mem_wb_t  : MEM->WB bus (118 bits)
//   MC_*      : bit positions inside mem_control
//   mem_state_e : memory-stage FSM encoding
package mips_bus_pkg;
  localparam int EXE_MEM_W = 154;
  localparam int MEM_WB_W  = 118;

  // mem_control = {inst_load, inst_store, ls_word, lb_sign}
  localparam int MC_LOAD  = 3;
  localparam int MC_STORE = 2;
  localparam int MC_WORD  = 1;
  localparam int MC_SIGN  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [3:0]  mem_control;
    logic [31:0] store_data;
    logic [31:0] exe_result;
    logic [31:0] lo_result;
    logic        hi_write, lo_write, mfhi, mflo, mtc0, mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall, eret, rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] pc;
  } exe_mem_t;

  typedef struct packed {
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write, lo_write, mfhi, mflo, mtc0, mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall, eret;
    logic [31:0] pc;
  } mem_wb_t;
endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte (little-endian) and
// sign/zero-extends it, or passes the whole word through for lw.
//   rdata   : raw RAM word
//   off     : byte offset addr[1:0]
//   ls_word : 1 = word access
//   lb_sign : 1 = sign-extend byte
//   data    : aligned 32-bit load value
module mem_load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic        ls_word,
  input  logic        lb_sign,
  output logic [31:0] data
);
  logic [7:0] b;

  always_comb begin
    b = rdata[7:0];
    case (off)
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      2'd3:    b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
  end

  assign data = ls_word ? rdata : {{24{lb_sign & b[7]}}, b};
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: word/byte load-store against a synchronous data RAM.
// Loads stall in an IDLE->WAIT->DONE FSM until RAM data returns; stores and
// non-memory instructions finish in the cycle they arrive.
//   clk, resetn    : clock, async active-low reset
//   MEM_valid      : stage holds a valid instruction
//   EXE_MEM_bus_r  : registered EXE->MEM bus
//   dm_rdata       : RAM read data (LOAD_LATENCY cycles after dm_addr)
//   dm_addr/wen/wdata : RAM request
//   MEM_over       : instruction completes this cycle
//   MEM_WB_bus     : MEM->WB bus
//   MEM_wdest      : destination register for hazard detection
//   MEM_pc         : pc of the instruction in this stage
module mem_stage
  import mips_bus_pkg::*;
#(
  parameter int LOAD_LATENCY = 1  // 1..7
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 MEM_valid,
  input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
  input  logic [31:0]          dm_rdata,
  output logic [31:0]          dm_addr,
  output logic [3:0]           dm_wen,
  output logic [31:0]          dm_wdata,
  output logic                 MEM_over,
  output logic [MEM_WB_W-1:0]  MEM_WB_bus,
  output logic [4:0]           MEM_wdest,
  output logic [31:0]          MEM_pc
);
  exe_mem_t   eb;
  mem_wb_t    wb;
  mem_state_e state;
  logic [2:0]  wait_cnt;
  logic [31:0] load_data_r;
  logic [31:0] aligned;
  logic        is_load, is_store, ls_word;

  assign eb = EXE_MEM_bus_r;

  // load and store both set decodes as a non-memory instruction
  assign is_load  = eb.mem_control[MC_LOAD]  & ~eb.mem_control[MC_STORE];
  assign is_store = eb.mem_control[MC_STORE] & ~eb.mem_control[MC_LOAD];
  assign ls_word  = eb.mem_control[MC_WORD];

  mem_load_align u_align (
    .rdata   (dm_rdata),
    .off     (eb.exe_result[1:0]),
    .ls_word (ls_word),
    .lb_sign (eb.mem_control[MC_SIGN]),
    .data    (aligned)
  );

  // Dropping MEM_valid while a load is in flight flushes it: back to IDLE
  // without touching load_data_r.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      wait_cnt    <= 3'd0;
      load_data_r <= 32'd0;
    end else begin
      case (state)
        IDLE: if (MEM_valid && is_load) begin
          state    <= WAIT;
          wait_cnt <= 3'(LOAD_LATENCY - 1);
        end
        WAIT: begin
          if (!MEM_valid) begin
            state <= IDLE;
          end else if (wait_cnt == 3'd0) begin
            load_data_r <= aligned;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign MEM_over = resetn & MEM_valid &
                    (((state == IDLE) & ~is_load) | (state == DONE));

  // Store lanes fire only on the arrival cycle, so a store is never repeated.
  always_comb begin
    dm_wen = 4'h0;
    if (resetn && MEM_valid && state == IDLE && is_store)
      dm_wen = ls_word ? 4'hF : (4'b0001 << eb.exe_result[1:0]);
  end

  assign dm_wdata = ls_word ? eb.store_data : {4{eb.store_data[7:0]}};
  assign dm_addr  = {eb.exe_result[31:2], 2'b00};

  always_comb begin
    wb.rf_wen     = eb.rf_wen;
    wb.rf_wdest   = eb.rf_wdest;
    wb.mem_result = is_load ? load_data_r : eb.exe_result;
    wb.lo_result  = eb.lo_result;
    wb.hi_write   = eb.hi_write;
    wb.lo_write   = eb.lo_write;
    wb.mfhi       = eb.mfhi;
    wb.mflo       = eb.mflo;
    wb.mtc0       = eb.mtc0;
    wb.mfc0       = eb.mfc0;
    wb.cp0r_addr  = eb.cp0r_addr;
    wb.syscall    = eb.syscall;
    wb.eret       = eb.eret;
    wb.pc         = eb.pc;
  end

  assign MEM_WB_bus = wb;
  assign MEM_wdest  = eb.rf_wdest & {5{MEM_valid}};
  assign MEM_pc     = eb.pc;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: one instance with LOAD_LATENCY=1 (a) and one with
// LOAD_LATENCY=3 (b) share a word RAM model; only one is active at a time.
module tb_mem_stage;
  logic         clk, resetn, mem_init, sel;
  logic         va, vb;
  logic [153:0] bus_a, bus_b;
  logic [31:0]  rd_a, rd_b, addr_a, addr_b, wd_a, wd_b, pc_a, pc_b, b1, b2;
  logic [3:0]   wen_a, wen_b;
  logic         ov_a, ov_b;
  logic [117:0] wb_a, wb_b;
  logic [4:0]   wdst_a, wdst_b;

  logic [31:0]  o_addr, o_wd, o_pc;
  logic [3:0]   o_wen;
  logic         o_over;
  logic [117:0] o_wb;
  logic [4:0]   o_wdest;

  logic [31:0]  mem [256];
  logic [31:0]  ref_mem [256];
  logic [31:0]  last_ld [2];
  int checks, errors;

  mem_stage #(.LOAD_LATENCY(1)) u_a (
    .clk(clk), .resetn(resetn), .MEM_valid(va), .EXE_MEM_bus_r(bus_a),
    .dm_rdata(rd_a), .dm_addr(addr_a), .dm_wen(wen_a), .dm_wdata(wd_a),
    .MEM_over(ov_a), .MEM_WB_bus(wb_a), .MEM_wdest(wdst_a), .MEM_pc(pc_a));

  mem_stage #(.LOAD_LATENCY(3)) u_b (
    .clk(clk), .resetn(resetn), .MEM_valid(vb), .EXE_MEM_bus_r(bus_b),
    .dm_rdata(rd_b), .dm_addr(addr_b), .dm_wen(wen_b), .dm_wdata(wd_b),
    .MEM_over(ov_b), .MEM_WB_bus(wb_b), .MEM_wdest(wdst_b), .MEM_pc(pc_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    o_addr  = sel ? addr_b : addr_a;
    o_wd    = sel ? wd_b   : wd_a;
    o_pc    = sel ? pc_b   : pc_a;
    o_wen   = sel ? wen_b  : wen_a;
    o_over  = sel ? ov_b   : ov_a;
    o_wb    = sel ? wb_b   : wb_a;
    o_wdest = sel ? wdst_b : wdst_a;
  end

  function automatic logic [31:0] init_word(input int k);
    return 32'h9E3779B9 * 32'(k) + 32'h01234567;
  endfunction

  // synchronous RAM: 1-cycle read for a, 3-cycle read for b
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (wen_a[k]) mem[addr_a[9:2]][8*k +: 8] <= wd_a[8*k +: 8];
        if (wen_b[k]) mem[addr_b[9:2]][8*k +: 8] <= wd_b[8*k +: 8];
      end
    end
    rd_a <= mem[addr_a[9:2]];
    b1   <= mem[addr_b[9:2]];
    b2   <= b1;
    rd_b <= b2;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one instruction on instance `which`, follow it to retirement.
  task automatic exec(input int which, input logic [3:0] mc, input logic [31:0] addr,
                      input logic [31:0] sd, input logic [4:0] wd);
    logic [31:0] pc, lo, res, word, b, ewd;
    logic [7:0] cp0;
    logic [5:0] fl;
    logic [1:0] se;
    logic rfw, ld, st, done, quiet;
    logic [3:0] ewen;
    logic [117:0] ewb;
    logic [153:0] bus;
    int lat, n, idx, off;
    pc = $urandom; lo = $urandom; cp0 = 8'($urandom); fl = 6'($urandom);
    se = 2'($urandom); rfw = 1'($urandom);
    ld = mc[3] & ~mc[2];
    st = mc[2] & ~mc[3];
    idx = int'(addr[9:2]);
    off = int'(addr[1:0]);
    word = ref_mem[idx];
    res = addr; ewen = 4'h0; ewd = 32'h0;
    if (ld) begin
      if (mc[1]) res = word;
      else begin
        b = (word >> (8*off)) & 32'hFF;
        res = (mc[0] && b >= 128) ? b - 32'd256 : b;
      end
    end
    if (st) begin
      if (mc[1]) begin
        ewen = 4'hF; ewd = sd; ref_mem[idx] = sd;
      end else begin
        ewen = 4'(1 << off); ewd = {4{sd[7:0]}};
        ref_mem[idx] = (word & ~(32'hFF << (8*off))) | ({24'd0, sd[7:0]} << (8*off));
      end
    end
    lat = ld ? (which != 0 ? 4 : 2) : 0;
    bus = {mc, sd, addr, lo, fl, cp0, se, rfw, wd, pc};
    ewb = {rfw, wd, res, lo, fl, cp0, se, pc};
    sel = which[0];
    @(posedge clk); #1;
    if (which != 0) begin bus_b = bus; vb = 1'b1; end
    else begin bus_a = bus; va = 1'b1; end
    n = 0; done = 1'b0; quiet = 1'b1;
    while (!done && n < 16) begin
      @(negedge clk);
      chk("wdest", o_wdest, wd);
      chk("pc", o_pc, pc);
      if ((ld || st) && n <= lat) chk("addr", o_addr, {addr[31:2], 2'b00});
      if (n == 0) begin
        chk("wen", o_wen, ewen);
        if (st) chk("wdata", o_wd, ewd);
      end else if (o_wen != 4'h0) quiet = 1'b0;
      if (o_over) begin
        chk("latency", n, lat);
        chk("wb_bus", o_wb, ewb);
        done = 1'b1;
      end
      n++;
    end
    if (!done) chk("timeout", 0, 1);
    if (ld) chk("wen_quiet", quiet, 1);
    @(posedge clk); #1;
    va = 1'b0; vb = 1'b0;
    if (ld) last_ld[which] = res;
  endtask

  // Start a lw, drop MEM_valid while waiting; the load must vanish.
  task automatic flush(input int which, input logic [31:0] addr);
    logic [153:0] bus;
    bus = {4'b1010, 32'd0, addr, 49'd0, 5'd9, 32'h400};
    sel = which[0];
    @(posedge clk); #1;
    if (which != 0) begin bus_b = bus; vb = 1'b1; end
    else begin bus_a = bus; va = 1'b1; end
    repeat (which != 0 ? 2 : 1) @(posedge clk);
    #1; va = 1'b0; vb = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("fl_over", o_over, 0);
      chk("fl_wen", o_wen, 0);
      chk("fl_wdest", o_wdest, 0);
      chk("fl_ldr", o_wb[111:80], last_ld[which]);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    resetn = 1'b0; mem_init = 1'b1; sel = 1'b0;
    for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
    last_ld[0] = 32'd0; last_ld[1] = 32'd0;
    // valid store presented while in reset: must not write or complete
    va = 1'b1; vb = 1'b0;
    bus_a = {4'b0110, 32'hDEADBEEF, 32'h1000, 86'd0};
    bus_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_over", o_over, 0);
    chk("rst_wen", o_wen, 0);
    @(posedge clk); #1;
    resetn = 1'b1; mem_init = 1'b0; va = 1'b0;
    bus_a[153:150] = 4'b1000;
    @(negedge clk);
    chk("rst_ldr", o_wb[111:80], 0);
    chk("rst_wdest", o_wdest, 0);

    // directed cases
    exec(0, 4'b0000, 32'h137, 32'h0, 5'd5);          // non-memory
    exec(0, 4'b0100, 32'h1002, 32'hA5, 5'd1);        // sb
    exec(0, 4'b0110, 32'h1000, 32'h80FF1234, 5'd2);  // sw
    exec(0, 4'b1001, 32'h1003, 32'h0, 5'd3);         // lb  -> FFFFFF80
    chk("lb_val", last_ld[0], 32'hFFFFFF80);
    exec(0, 4'b1000, 32'h1003, 32'h0, 5'd3);         // lbu -> 00000080
    chk("lbu_val", last_ld[0], 32'h00000080);
    exec(1, 4'b1010, 32'h1000, 32'h0, 5'd4);         // lw, latency 3
    chk("lw_val", last_ld[1], 32'h80FF1234);
    exec(0, 4'b1110, 32'h1004, 32'h55, 5'd6);        // load+store set: non-memory

    flush(0, 32'h14);
    exec(0, 4'b1010, 32'h18, 32'h0, 5'd7);
    flush(1, 32'h14);
    exec(1, 4'b1010, 32'h18, 32'h0, 5'd8);

    // async reset in the middle of a latency-3 load
    sel = 1'b1;
    bus_b = {4'b1010, 32'd0, 32'h1000, 49'd0, 5'd9, 32'h400};
    @(posedge clk); #1 vb = 1'b1;
    @(posedge clk); #1 resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_over", o_over, 0);
    chk("mid_rst_ldr", o_wb[111:80], 0);
    @(posedge clk); #1;
    resetn = 1'b1; vb = 1'b0;
    last_ld[0] = 32'd0; last_ld[1] = 32'd0;
    @(negedge clk);
    chk("post_rst_ldr", o_wb[111:80], 0);
    exec(1, 4'b1010, 32'h1000, 32'h0, 5'd10);
    exec(0, 4'b1001, 32'h1003, 32'h0, 5'd11);

    // random mix
    for (int i = 0; i < 80; i++) begin
      int k;
      logic [3:0] mc;
      logic [31:0] addr;
      k = $urandom_range(0, 6);
      case (k)
        0: mc = {2'b00, 2'($urandom)};
        1: mc = 4'b0110;
        2: mc = 4'b0100;
        3: mc = {3'b101, 1'($urandom)};
        4: mc = 4'b1001;
        5: mc = 4'b1000;
        default: mc = {2'b11, 2'($urandom)};
      endcase
      addr = ($urandom & 32'hFFFFFC00) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
      exec(int'($urandom_range(0, 1)), mc, addr, $urandom, 5'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
